maze_plan_seq: RTL and testbench

- Travel-plan sequencer for the maze runner.
- Accepts the 16-bit travel plan delivered by the UART command path.
- Enables line following, detects gaps in the line and issues turn requests with an updated desired heading to the heading/motion controller.
- Stops and sounds the buzzer on bump. Sits between the UART wrapper and the motion controller inside MazeRunner.

---
 rtl/maze_pkg.sv | 27 ++
 rtl/maze_plan_seq_sat_cnt_cmp.sv | 37 +++
 rtl/maze_plan_seq.sv | 207 ++++++++++++++++++++
 tb/tb_maze_plan_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze runner travel-plan sequencer.
//   seq_state_t   : sequencer state encoding
//   PLAN_*        : 2-bit travel plan entry codes
//   HDG_W/PLAN_W  : heading and plan widths
//   HDG_90_DEF    : default heading step for a 90 degree turn (4096 counts/rev)
package maze_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FOLLOW,
    ST_TURN,
    ST_REACQ,
    ST_BUMP,
    ST_DONE
  } seq_state_t;

  localparam int HDG_W  = 12;
  localparam int PLAN_W = 16;

  localparam logic [1:0] PLAN_END      = 2'b00;
  localparam logic [1:0] PLAN_LEFT     = 2'b01;
  localparam logic [1:0] PLAN_RIGHT    = 2'b10;
  localparam logic [1:0] PLAN_STRAIGHT = 2'b11;

  localparam logic signed [HDG_W-1:0] HDG_90_DEF = 12'sh400;

endpackage

// File: rtl/maze_plan_seq_sat_cnt_cmp.sv
// Saturating up-counter with synchronous clear, hold and terminal-count flag.
//   clk, rst_n : clock, asynchronous active-low reset (count returns to 0)
//   clr        : synchronous clear, has priority over en
//   en         : count enable; the count holds when low and sticks at TERM
//   tc         : high while the count equals TERM
module sat_cnt_cmp #(
  parameter int W    = 12,
  parameter int TERM = 4095
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TERM_V = TERM[W-1:0];

  logic [W-1:0] cnt;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == TERM_V) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign tc = (cnt == TERM_V);

endmodule

// File: rtl/maze_plan_seq.sv
// Travel-plan sequencer for the maze runner. Takes the 16-bit plan from the
// UART path, runs line following, turns at qualified gaps in the line and
// stops with the buzzer on a bump.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   cmd, cmd_rdy      : travel plan (eight 2-bit entries, entry 0 in [1:0]) and its valid level
//   clr_cmd_rdy       : one-cycle acknowledge of cmd
//   line_present      : synchronous IR line sensor
//   BMPL_n, BMPR_n    : asynchronous active-low bump switches
//   turn_done         : motion controller has reached dsrd_hdg
//   go                : line following / motor enable
//   turn_req          : one-cycle pulse, dsrd_hdg has a new value
//   dsrd_hdg          : desired heading, wraps modulo 4096
//   buzz_en           : piezo buzzer enable
//   plan_done         : level, plan ran to its end entry
module maze_plan_seq
  import maze_pkg::*;
#(
  parameter int                        GAP_CYC   = 4096,
  parameter int                        REACQ_CYC = 65536,
  parameter logic signed [HDG_W-1:0]   HDG_90    = HDG_90_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PLAN_W-1:0]        cmd,
  input  logic                     cmd_rdy,
  output logic                     clr_cmd_rdy,
  input  logic                     line_present,
  input  logic                     BMPL_n,
  input  logic                     BMPR_n,
  input  logic                     turn_done,
  output logic                     go,
  output logic                     turn_req,
  output logic signed [HDG_W-1:0]  dsrd_hdg,
  output logic                     buzz_en,
  output logic                     plan_done
);

  localparam int GAP_W   = (GAP_CYC   > 1) ? $clog2(GAP_CYC)   : 1;
  localparam int REACQ_W = (REACQ_CYC > 1) ? $clog2(REACQ_CYC) : 1;

  seq_state_t                state, state_nxt;
  logic [PLAN_W-1:0]         plan, plan_nxt;
  logic signed [HDG_W-1:0]   hdg_nxt;
  logic                      go_nxt, treq_nxt, clr_nxt, buzz_nxt, done_nxt;

  logic bmpl_p0, bmpl_p1, bmpr_p0, bmpr_p1;
  logic bump;

  logic gap_clr, gap_en, gap_tc;
  logic reacq_clr, reacq_en, reacq_tc;

  // Heading steps wrap naturally in 12 bits (C00 + 400 = 000, 000 - 400 = C00).
  function automatic logic signed [HDG_W-1:0] hdg_step(
    input logic signed [HDG_W-1:0] hdg,
    input logic signed [HDG_W-1:0] delta,
    input logic                    left
  );
    return left ? hdg + delta : hdg - delta;
  endfunction

  // Stage p0/p1: two-flop synchronizers for the asynchronous bump switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmpl_p0 <= 1'b1;
      bmpl_p1 <= 1'b1;
      bmpr_p0 <= 1'b1;
      bmpr_p1 <= 1'b1;
    end else begin
      bmpl_p0 <= BMPL_n;
      bmpl_p1 <= bmpl_p0;
      bmpr_p0 <= BMPR_n;
      bmpr_p1 <= bmpr_p0;
    end
  end

  assign bump = ~bmpl_p1 | ~bmpr_p1;

  sat_cnt_cmp #(.W(GAP_W), .TERM(GAP_CYC - 1)) u_gap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (gap_clr),
    .en    (gap_en),
    .tc    (gap_tc)
  );

  sat_cnt_cmp #(.W(REACQ_W), .TERM(REACQ_CYC - 1)) u_reacq_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (reacq_clr),
    .en    (reacq_en),
    .tc    (reacq_tc)
  );

  always_comb begin
    state_nxt = state;
    plan_nxt  = plan;
    hdg_nxt   = dsrd_hdg;
    treq_nxt  = 1'b0;
    clr_nxt   = 1'b0;
    buzz_nxt  = buzz_en;
    done_nxt  = plan_done;
    gap_clr   = 1'b1;
    gap_en    = 1'b0;
    reacq_clr = 1'b1;
    reacq_en  = 1'b0;

    case (state)
      ST_IDLE, ST_DONE, ST_BUMP: begin
        // A new plan keeps the current heading; only status flags restart.
        if (cmd_rdy) begin
          plan_nxt  = cmd;
          clr_nxt   = 1'b1;
          done_nxt  = 1'b0;
          buzz_nxt  = 1'b0;
          state_nxt = ST_FOLLOW;
        end
      end

      ST_FOLLOW: begin
        gap_clr = line_present;
        gap_en  = ~line_present;
        if (bump) begin
          plan_nxt  = '0;
          buzz_nxt  = 1'b1;
          state_nxt = ST_BUMP;
        end else if (gap_tc && !line_present) begin
          gap_clr = 1'b1;
          case (plan[1:0])
            PLAN_END: begin
              done_nxt  = 1'b1;
              state_nxt = ST_DONE;
            end
            PLAN_LEFT: begin
              hdg_nxt   = hdg_step(dsrd_hdg, HDG_90, 1'b1);
              treq_nxt  = 1'b1;
              plan_nxt  = {2'b00, plan[PLAN_W-1:2]};
              state_nxt = ST_TURN;
            end
            PLAN_RIGHT: begin
              hdg_nxt   = hdg_step(dsrd_hdg, HDG_90, 1'b0);
              treq_nxt  = 1'b1;
              plan_nxt  = {2'b00, plan[PLAN_W-1:2]};
              state_nxt = ST_TURN;
            end
            default: begin
              plan_nxt  = {2'b00, plan[PLAN_W-1:2]};
              state_nxt = ST_REACQ;
            end
          endcase
        end
      end

      ST_TURN: begin
        // turn_done is not trusted during the turn_req cycle: it may still
        // reflect the previous heading.
        if (bump) begin
          plan_nxt  = '0;
          buzz_nxt  = 1'b1;
          state_nxt = ST_BUMP;
        end else if (turn_done && !turn_req) begin
          state_nxt = ST_REACQ;
        end
      end

      ST_REACQ: begin
        reacq_clr = reacq_tc;
        reacq_en  = 1'b1;
        if (bump) begin
          reacq_clr = 1'b1;
          plan_nxt  = '0;
          buzz_nxt  = 1'b1;
          state_nxt = ST_BUMP;
        end else if (reacq_tc) begin
          state_nxt = ST_FOLLOW;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    go_nxt = (state_nxt == ST_FOLLOW) || (state_nxt == ST_REACQ);
  end

  // Stage p0: registered state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      plan        <= '0;
      dsrd_hdg    <= '0;
      go          <= 1'b0;
      turn_req    <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      buzz_en     <= 1'b0;
      plan_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      plan        <= plan_nxt;
      dsrd_hdg    <= hdg_nxt;
      go          <= go_nxt;
      turn_req    <= treq_nxt;
      clr_cmd_rdy <= clr_nxt;
      buzz_en     <= buzz_nxt;
      plan_done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_maze_plan_seq.sv
// Directed bench for maze_plan_seq with an in-bench reference model of the
// travel-plan rules, checked every cycle, plus literal expectations.
module tb_maze_plan_seq;

  localparam int GAP   = 8;
  localparam int REACQ = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = '0;
  logic        cmd_rdy = 1'b0;
  logic        clr_cmd_rdy;
  logic        line_present = 1'b1;
  logic        BMPL_n = 1'b1;
  logic        BMPR_n = 1'b1;
  logic        turn_done = 1'b0;
  logic        go;
  logic        turn_req;
  logic signed [11:0] dsrd_hdg;
  logic        buzz_en;
  logic        plan_done;

  int vectors = 0;
  int miscompares = 0;
  int treq_cnt = 0;
  int clr_cnt = 0;

  maze_plan_seq #(.GAP_CYC(GAP), .REACQ_CYC(REACQ), .HDG_90(12'sh400)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .line_present (line_present),
    .BMPL_n       (BMPL_n),
    .BMPR_n       (BMPR_n),
    .turn_done    (turn_done),
    .go           (go),
    .turn_req     (turn_req),
    .dsrd_hdg     (dsrd_hdg),
    .buzz_en      (buzz_en),
    .plan_done    (plan_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_FOLLOW = 1, M_TURN = 2, M_REACQ = 3, M_BUMP = 4, M_DONE = 5;

  int   m_mode = M_IDLE;
  int   m_plan[$];
  int   m_hdg = 0;
  int   m_low = 0;
  int   m_left = 0;
  bit   m_armed = 1'b0;
  bit   m_go = 1'b0, m_treq = 1'b0, m_clr = 1'b0, m_buzz = 1'b0, m_done = 1'b0;
  bit [1:0] m_bh = 2'b00;

  function automatic int head();
    return (m_plan.size() > 0) ? m_plan[0] : 0;
  endfunction

  task automatic model_bump();
    m_mode <= M_BUMP;
    m_go   <= 1'b0;
    m_buzz <= 1'b1;
    m_plan.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE; m_hdg <= 0; m_low <= 0; m_left <= 0; m_armed <= 1'b0;
      m_go <= 1'b0; m_treq <= 1'b0; m_clr <= 1'b0; m_buzz <= 1'b0; m_done <= 1'b0;
      m_bh <= 2'b00;
      m_plan.delete();
    end else begin
      m_bh   <= {m_bh[0], !(BMPL_n && BMPR_n)};
      m_treq <= 1'b0;
      m_clr  <= 1'b0;
      case (m_mode)
        M_IDLE, M_DONE, M_BUMP: begin
          if (cmd_rdy) begin
            m_plan.delete();
            for (int i = 0; i < 8; i++) m_plan.push_back(int'(cmd[2*i +: 2]));
            m_clr <= 1'b1; m_done <= 1'b0; m_buzz <= 1'b0;
            m_mode <= M_FOLLOW; m_go <= 1'b1; m_low <= 0;
          end
        end
        M_FOLLOW: begin
          if (m_bh[1]) model_bump();
          else if (!line_present) begin
            if (m_low == GAP - 1) begin
              m_low <= 0;
              case (head())
                0: begin m_mode <= M_DONE; m_go <= 1'b0; m_done <= 1'b1; end
                1: begin
                  m_hdg <= (m_hdg + 1024) % 4096; m_treq <= 1'b1; m_go <= 1'b0;
                  m_mode <= M_TURN; m_armed <= 1'b0; m_plan.delete(0);
                end
                2: begin
                  m_hdg <= (m_hdg + 3072) % 4096; m_treq <= 1'b1; m_go <= 1'b0;
                  m_mode <= M_TURN; m_armed <= 1'b0; m_plan.delete(0);
                end
                default: begin m_mode <= M_REACQ; m_left <= REACQ; m_plan.delete(0); end
              endcase
            end else m_low <= m_low + 1;
          end else m_low <= 0;
        end
        M_TURN: begin
          if (m_bh[1]) model_bump();
          else if (!m_armed) m_armed <= 1'b1;
          else if (turn_done) begin m_mode <= M_REACQ; m_left <= REACQ; m_go <= 1'b1; end
        end
        M_REACQ: begin
          if (m_bh[1]) model_bump();
          else if (m_left == 1) begin m_mode <= M_FOLLOW; m_low <= 0; end
          else m_left <= m_left - 1;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("go",          32'(go),          32'(m_go));
    chk("turn_req",    32'(turn_req),    32'(m_treq));
    chk("clr_cmd_rdy", 32'(clr_cmd_rdy), 32'(m_clr));
    chk("buzz_en",     32'(buzz_en),     32'(m_buzz));
    chk("plan_done",   32'(plan_done),   32'(m_done));
    chk("dsrd_hdg",    {20'd0, dsrd_hdg}, 32'(m_hdg));
    if (turn_req) treq_cnt++;
    if (clr_cmd_rdy) clr_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] c);
    int c0;
    c0 = clr_cnt;
    cmd = c;
    cmd_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (clr_cmd_rdy) break;
    end
    chk("cmd_ack", 32'(clr_cmd_rdy), 32'd1);
    cmd_rdy = 1'b0;
    cyc(1);
    chk("ack_once", 32'(clr_cnt - c0), 32'd1);
    chk("ack_pulse_end", 32'(clr_cmd_rdy), 32'd0);
    chk("go_after_ack", 32'(go), 32'd1);
  endtask

  task automatic gap(input int n);
    line_present = 1'b0;
    cyc(n);
    line_present = 1'b1;
  endtask

  task automatic do_turn();
    cyc(1);
    turn_done = 1'b1;
    cyc(1);
    turn_done = 1'b0;
    cyc(40);
  endtask

  logic [11:0] exp_hdg[4];
  int t0, c0;

  initial begin
    exp_hdg[0] = 12'hC00; exp_hdg[1] = 12'h800; exp_hdg[2] = 12'h400; exp_hdg[3] = 12'h000;

    // Reset state
    cyc(2);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_hdg", {20'd0, dsrd_hdg}, 32'd0);
    chk("rst_done", 32'(plan_done), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // 1: single left turn then end
    send(16'h0001);
    gap(GAP);
    chk("t1_treq", 32'(turn_req), 32'd1);
    chk("t1_hdg", {20'd0, dsrd_hdg}, 32'h400);
    chk("t1_go", 32'(go), 32'd0);
    do_turn();
    chk("t1_go_reacq", 32'(go), 32'd1);
    gap(GAP);
    chk("t1_done", 32'(plan_done), 32'd1);
    chk("t1_go_done", 32'(go), 32'd0);

    // 2: turn_done held before the pulse is only honoured a cycle later
    send(16'h0002);
    turn_done = 1'b1;
    gap(GAP);
    chk("t2_hdg0", {20'd0, dsrd_hdg}, 32'h000);
    cyc(1);
    chk("t2_ignore_early_done", 32'(go), 32'd0);
    cyc(1);
    chk("t2_reacq", 32'(go), 32'd1);
    turn_done = 1'b0;
    cyc(40);
    gap(GAP);
    chk("t2_done", 32'(plan_done), 32'd1);
    // four right turns, wrapping through zero
    send(16'h00AA);
    for (int k = 0; k < 4; k++) begin
      gap(GAP);
      chk("t2_treq", 32'(turn_req), 32'd1);
      chk("t2_hdg_seq", {20'd0, dsrd_hdg}, {20'd0, exp_hdg[k]});
      do_turn();
    end
    gap(GAP);
    chk("t2_done_after_4", 32'(plan_done), 32'd1);

    // 3: straight through, reacquire window ignores a gap
    send(16'h0003);
    gap(GAP);
    chk("t3_no_treq", 32'(turn_req), 32'd0);
    chk("t3_go_held", 32'(go), 32'd1);
    cyc(3);
    gap(GAP);
    chk("t3_gap_ignored", 32'(plan_done), 32'd0);
    chk("t3_go_still", 32'(go), 32'd1);
    cyc(40);
    gap(GAP);
    chk("t3_done", 32'(plan_done), 32'd1);

    // 4: interrupted gap restarts the count
    send(16'h0001);
    t0 = treq_cnt;
    line_present = 1'b0; cyc(GAP - 1);
    line_present = 1'b1; cyc(1);
    line_present = 1'b0; cyc(GAP - 1);
    line_present = 1'b1; cyc(2);
    chk("t4_no_action", 32'(treq_cnt - t0), 32'd0);
    gap(GAP);
    chk("t4_treq", 32'(turn_req), 32'd1);
    chk("t4_hdg", {20'd0, dsrd_hdg}, 32'h400);
    do_turn();

    // 5: bump during follow, then bump coinciding with a qualifying gap
    BMPL_n = 1'b0;
    cyc(3);
    chk("t5_bump_go", 32'(go), 32'd0);
    chk("t5_bump_buzz", 32'(buzz_en), 32'd1);
    BMPL_n = 1'b1;
    cyc(3);
    send(16'h0001);
    chk("t5_buzz_clr", 32'(buzz_en), 32'd0);
    t0 = treq_cnt;
    line_present = 1'b0;
    cyc(GAP - 3);
    BMPL_n = 1'b0;
    cyc(3);
    chk("t5_bump_wins_treq", 32'(treq_cnt - t0), 32'd0);
    chk("t5_bump_wins_buzz", 32'(buzz_en), 32'd1);
    chk("t5_bump_wins_hdg", {20'd0, dsrd_hdg}, 32'h400);
    BMPL_n = 1'b1;
    line_present = 1'b1;
    cyc(4);
    send(16'h0001);

    // 6: reset in TURN, then cmd_rdy held across REACQ
    gap(GAP);
    chk("t6_treq", 32'(turn_req), 32'd1);
    cyc(1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_go", 32'(go), 32'd0);
    chk("t6_rst_treq", 32'(turn_req), 32'd0);
    chk("t6_rst_hdg", {20'd0, dsrd_hdg}, 32'd0);
    chk("t6_rst_buzz", 32'(buzz_en), 32'd0);
    chk("t6_rst_done", 32'(plan_done), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    t0 = treq_cnt;
    cyc(3);
    chk("t6_no_reissue", 32'(treq_cnt - t0), 32'd0);
    send(16'h0003);
    gap(GAP);
    cmd = 16'h0001;
    cmd_rdy = 1'b1;
    c0 = clr_cnt;
    cyc(40);
    chk("t6_no_ack_busy", 32'(clr_cnt - c0), 32'd0);
    gap(GAP);
    chk("t6_done", 32'(plan_done), 32'd1);
    chk("t6_no_ack_yet", 32'(clr_cmd_rdy), 32'd0);
    cyc(1);
    chk("t6_ack_in_done", 32'(clr_cmd_rdy), 32'd1);
    chk("t6_done_clr", 32'(plan_done), 32'd0);
    cmd_rdy = 1'b0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
